// File: rtl/uart_rx_frame_ctrl_pkg.sv
// Shared definitions for the UART frame controller: state encoding,
// rejection codes and the link timing the defaults are derived from.
package uart_rx_frame_ctrl_pkg;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LEN  = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_CHK  = 3'd3;
    localparam logic [2:0] S_OUT  = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE = S_IDLE,
        ST_LEN  = S_LEN,
        ST_DATA = S_DATA,
        ST_CHK  = S_CHK,
        ST_OUT  = S_OUT
    } frame_state_t;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_LEN  = 2'd1;
    localparam logic [1:0] ERR_CHK  = 2'd2;
    localparam logic [1:0] ERR_TMO  = 2'd3;

    localparam logic [7:0] HDR_DEFAULT = 8'hA5;

    // 8N1 framing: start + 8 data + stop = 10 bit times per byte.
    localparam int CLK_HZ            = 50_000_000;
    localparam int COM_BAUD          = 115_200;
    localparam int COM_BITS_PER_BYTE = 10;
    localparam int BYTE_CLKS         = (CLK_HZ / COM_BAUD) * COM_BITS_PER_BYTE;
    localparam int TIMEOUT_DEFAULT   = 10 * BYTE_CLKS;

    // Running frame checksum: plain 8-bit wrapping add.
    function automatic logic [7:0] sum8(input logic [7:0] a, input logic [7:0] b);
        return a + b;
    endfunction

endpackage

// File: rtl/uart_rx_frame_ctrl_frame_buf.sv
// Payload buffer: register array with one write port and a registered
// read port. Depth is the power of two covered by the address width.
module uart_rx_frame_ctrl_frame_buf
    import uart_rx_frame_ctrl_pkg::*;
#(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [2**AW];

    // Storage array; no reset needed, contents are only read after being written.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read so the controller can present data one cycle after addressing it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Frame-level receive controller: parses HDR/LEN/payload/CHK from the
// byte receiver, supervises inter-byte silence, and streams one accepted
// payload to the command decoder over valid/ready.
//
//   state | meaning
//   IDLE  | hunting for header byte
//   LEN   | waiting for length byte
//   DATA  | collecting payload bytes into the buffer
//   CHK   | waiting for checksum byte
//   OUT   | streaming accepted payload; incoming bytes are dropped
module uart_rx_frame_ctrl
    import uart_rx_frame_ctrl_pkg::*;
#(
    parameter int         MAX_LEN      = 16,
    parameter logic [7:0] HDR          = HDR_DEFAULT,
    parameter int         TIMEOUT_CLKS = TIMEOUT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_stb,
    input  logic [7:0] rx_dat,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_last,
    input  logic       out_ready,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic [7:0] ovr_cnt,
    output logic       busy
);

    localparam int IW = $clog2(MAX_LEN + 1);
    localparam int BW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT_CLKS);

    localparam logic [IW-1:0] IDX_ONE   = IW'(1);
    localparam logic [BW-1:0] ADDR_ONE  = BW'(1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CLKS - 1);
    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

    frame_state_t  state_q, state_nxt;
    logic [IW-1:0] len_q, len_nxt;
    logic [IW-1:0] idx_q, idx_nxt;
    logic [7:0]    sum_q, sum_nxt;
    logic [TW-1:0] tmo_q, tmo_nxt;
    logic          ok_nxt, err_nxt;
    logic [1:0]    code_nxt;
    logic [7:0]    ovr_nxt;

    logic          buf_we;
    logic [BW-1:0] buf_raddr;
    logic [7:0]    buf_rdata;

    logic [7:0]    chk_sum;
    logic [IW-1:0] last_idx;
    logic          in_frame;
    logic          tmo_hit;
    logic          fire;

    assign chk_sum   = sum8(sum_q, rx_dat);
    assign last_idx  = len_q - IDX_ONE;
    assign in_frame  = (state_q == ST_LEN) || (state_q == ST_DATA) || (state_q == ST_CHK);
    assign tmo_hit   = (tmo_q == TMO_LAST);

    assign out_valid = (state_q == ST_OUT);
    assign out_last  = out_valid && (idx_q == last_idx);
    assign out_data  = out_valid ? buf_rdata : 8'h00;
    assign fire      = out_valid && out_ready;
    assign busy      = (state_q != ST_IDLE);

    uart_rx_frame_ctrl_frame_buf #(
        .AW(BW)
    ) u_frame_buf (
        .clk  (clk),
        .rst_n(rst_n),
        .we   (buf_we),
        .waddr(idx_q[BW-1:0]),
        .wdata(rx_dat),
        .raddr(buf_raddr),
        .rdata(buf_rdata)
    );

    // Next-state, datapath updates and pulse requests.
    always_comb begin
        state_nxt = state_q;
        len_nxt   = len_q;
        idx_nxt   = idx_q;
        sum_nxt   = sum_q;
        tmo_nxt   = '0;
        ok_nxt    = 1'b0;
        err_nxt   = 1'b0;
        code_nxt  = err_code;
        ovr_nxt   = ovr_cnt;
        buf_we    = 1'b0;
        buf_raddr = '0;

        // A byte arriving in the timeout cycle takes precedence, so silence is only judged without rx_stb.
        if (in_frame && !rx_stb) begin
            if (tmo_hit) begin
                err_nxt   = 1'b1;
                code_nxt  = ERR_TMO;
                state_nxt = ST_IDLE;
            end else begin
                tmo_nxt = tmo_q + TW'(1);
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (rx_stb && (rx_dat == HDR)) begin
                    state_nxt = ST_LEN;
                end
            end
            ST_LEN: begin
                if (rx_stb) begin
                    sum_nxt = rx_dat;
                    idx_nxt = '0;
                    if (rx_dat > MAX_LEN_B) begin
                        err_nxt   = 1'b1;
                        code_nxt  = ERR_LEN;
                        state_nxt = ST_IDLE;
                    end else begin
                        len_nxt   = rx_dat[IW-1:0];
                        state_nxt = (rx_dat == 8'd0) ? ST_CHK : ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (rx_stb) begin
                    buf_we  = 1'b1;
                    sum_nxt = sum8(sum_q, rx_dat);
                    idx_nxt = idx_q + IDX_ONE;
                    if (idx_q == last_idx) begin
                        state_nxt = ST_CHK;
                    end
                end
            end
            ST_CHK: begin
                // buf_raddr stays 0 here so buf[0] is on rdata alongside frame_ok.
                if (rx_stb) begin
                    if (chk_sum == 8'h00) begin
                        ok_nxt    = 1'b1;
                        idx_nxt   = '0;
                        state_nxt = (len_q == '0) ? ST_IDLE : ST_OUT;
                    end else begin
                        err_nxt   = 1'b1;
                        code_nxt  = ERR_CHK;
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_OUT: begin
                buf_raddr = idx_q[BW-1:0];
                if (rx_stb && (ovr_cnt != 8'hFF)) begin
                    ovr_nxt = ovr_cnt + 8'd1;
                end
                if (fire) begin
                    if (out_last) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        idx_nxt   = idx_q + IDX_ONE;
                        buf_raddr = idx_q[BW-1:0] + ADDR_ONE;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            len_q     <= '0;
            idx_q     <= '0;
            sum_q     <= '0;
            tmo_q     <= '0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            err_code  <= ERR_NONE;
            ovr_cnt   <= '0;
        end else begin
            state_q   <= state_nxt;
            len_q     <= len_nxt;
            idx_q     <= idx_nxt;
            sum_q     <= sum_nxt;
            tmo_q     <= tmo_nxt;
            frame_ok  <= ok_nxt;
            frame_err <= err_nxt;
            err_code  <= code_nxt;
            ovr_cnt   <= ovr_nxt;
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Self-checking bench for uart_rx_frame_ctrl: directed frames followed by
// randomized frames judged by a byte-list reference model.
module tb_uart_rx_frame_ctrl;

    localparam int         MAX_LEN = 16;
    localparam logic [7:0] HDR     = 8'hA5;
    localparam int         TMO     = 300;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_stb = 1'b0;
    logic [7:0] rx_dat = 8'h00;
    logic       out_ready = 1'b0;
    logic       out_valid, out_last, frame_ok, frame_err, busy;
    logic [7:0] out_data, ovr_cnt;
    logic [1:0] err_code;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] pay_q[$];
    logic [7:0] got_q[$];
    logic       got_last_q[$];
    logic [7:0] prev_data = 8'h00;
    logic       prev_stall = 1'b0;

    always #10 clk = ~clk;

    uart_rx_frame_ctrl #(
        .MAX_LEN(MAX_LEN),
        .HDR(HDR),
        .TIMEOUT_CLKS(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rx_stb(rx_stb), .rx_dat(rx_dat),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
        .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code),
        .ovr_cnt(ovr_cnt), .busy(busy)
    );

    function automatic void check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endfunction

    // Reference: checksum byte making len + payload + chk == 0 mod 256.
    function automatic logic [7:0] model_chk(input logic [7:0] len);
        int s = int'(len);
        foreach (pay_q[i]) s += int'(pay_q[i]);
        return 8'((256 - (s % 256)) % 256);
    endfunction

    // Reference: rejection code for a frame (0 = accepted).
    function automatic int model_code(input logic [7:0] len, input logic [7:0] chk);
        int s;
        if (int'(len) > MAX_LEN) return 1;
        s = int'(len) + int'(chk);
        foreach (pay_q[i]) s += int'(pay_q[i]);
        return ((s % 256) == 0) ? 0 : 2;
    endfunction

    // Collect transfers and check data stability under backpressure.
    always @(negedge clk) begin
        if (out_valid && prev_stall) check("hold_stable", 32'(out_data), 32'(prev_data));
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        if (out_valid && out_ready) begin
            got_q.push_back(out_data);
            got_last_q.push_back(out_last);
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog expired vectors=%0d miscompares=%0d", vectors, miscompares);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_dat = b;
        rx_stb = 1'b1;
        tick();
        rx_stb = 1'b0;
        rx_dat = 8'($urandom);
    endtask

    task automatic send_body(input logic [7:0] len, input int gapmax);
        idle(int'($urandom_range(0, gapmax)));
        send_byte(HDR);
        idle(int'($urandom_range(0, gapmax)));
        send_byte(len);
        if (int'(len) <= MAX_LEN) begin
            foreach (pay_q[i]) begin
                idle(int'($urandom_range(0, gapmax)));
                send_byte(pay_q[i]);
            end
        end
    endtask

    task automatic wait_idle(input string tag, input int bound, input bit rnd);
        int n = 0;
        while (busy && n < bound) begin
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    task automatic compare_payload(input string tag);
        check({tag, "_count"}, 32'(got_q.size()), 32'(pay_q.size()));
        for (int i = 0; i < pay_q.size() && i < got_q.size(); i++) begin
            check({tag, "_data"}, 32'(got_q[i]), 32'(pay_q[i]));
            check({tag, "_last"}, 32'(got_last_q[i]), 32'(i == pay_q.size() - 1));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_data"},  32'(out_data),  32'd0);
        check({tag, "_last"},  32'(out_last),  32'd0);
        check({tag, "_ok"},    32'(frame_ok),  32'd0);
        check({tag, "_err"},   32'(frame_err), 32'd0);
        check({tag, "_code"},  32'(err_code),  32'd0);
        check({tag, "_ovr"},   32'(ovr_cnt),   32'd0);
        check({tag, "_busy"},  32'(busy),      32'd0);
    endtask

    initial begin
        logic [7:0] len;
        logic [7:0] chk;
        logic [7:0] b;
        int         code;
        logic [1:0] last_code;

        // Reset state
        idle(3);
        check_all_zero("reset");
        rst_n = 1'b1;
        idle(2);

        // Good 3-byte frame, continuous ready
        out_ready = 1'b1;
        pay_q = '{8'h11, 8'h22, 8'h33};
        send_body(8'd3, 0);
        chk = model_chk(8'd3);
        send_byte(chk);
        check("good_ok", 32'(frame_ok), 32'd1);
        check("good_valid", 32'(out_valid), 32'd1);
        check("good_d0", 32'(out_data), 32'h11);
        check("good_l0", 32'(out_last), 32'd0);
        tick();
        check("good_d1", 32'(out_data), 32'h22);
        tick();
        check("good_d2", 32'(out_data), 32'h33);
        check("good_l2", 32'(out_last), 32'd1);
        tick();
        check("good_done_valid", 32'(out_valid), 32'd0);
        check("good_done_busy", 32'(busy), 32'd0);

        // Bad checksum, then a good 1-byte frame
        pay_q = '{8'h10, 8'h20};
        send_body(8'd2, 1);
        send_byte(8'h00);
        check("badchk_err", 32'(frame_err), 32'(model_code(8'd2, 8'h00) != 0));
        check("badchk_code", 32'(err_code), 32'd2);
        check("badchk_valid", 32'(out_valid), 32'd0);
        pay_q = '{8'h7F};
        got_q.delete(); got_last_q.delete();
        send_body(8'd1, 1);
        send_byte(model_chk(8'd1));
        check("after_bad_ok", 32'(frame_ok), 32'd1);
        wait_idle("after_bad_drain", 50, 1'b0);
        compare_payload("after_bad");

        // Oversized length
        send_byte(HDR);
        send_byte(8'(MAX_LEN + 1));
        check("len_err", 32'(frame_err), 32'd1);
        check("len_code", 32'(err_code), 32'd1);
        check("len_busy", 32'(busy), 32'd0);

        // Zero-length frame
        pay_q.delete();
        send_body(8'd0, 0);
        send_byte(model_chk(8'd0));
        check("zero_ok", 32'(frame_ok), 32'd1);
        check("zero_valid", 32'(out_valid), 32'd0);
        check("zero_busy", 32'(busy), 32'd0);

        // Timeout after silence
        send_byte(HDR); send_byte(8'd2); send_byte(8'h55);
        idle(TMO - 1);
        check("tmo_early_err", 32'(frame_err), 32'd0);
        check("tmo_early_busy", 32'(busy), 32'd1);
        tick();
        check("tmo_err", 32'(frame_err), 32'd1);
        check("tmo_code", 32'(err_code), 32'd3);
        check("tmo_busy", 32'(busy), 32'd0);

        // Byte landing in the timeout cycle wins
        pay_q = '{8'h55, 8'h66};
        send_byte(HDR); send_byte(8'd2); send_byte(8'h55);
        idle(TMO - 1);
        send_byte(8'h66);
        check("tmo_race_err", 32'(frame_err), 32'd0);
        check("tmo_race_busy", 32'(busy), 32'd1);
        got_q.delete(); got_last_q.delete();
        send_byte(model_chk(8'd2));
        check("tmo_race_ok", 32'(frame_ok), 32'd1);
        wait_idle("tmo_race_drain", 50, 1'b0);
        compare_payload("tmo_race");
        check("code_held", 32'(err_code), 32'd3);

        // Backpressure with overrun bytes (one of them a header)
        out_ready = 1'b0;
        pay_q = '{8'h11, 8'h22, 8'h33};
        send_body(8'd3, 1);
        send_byte(model_chk(8'd3));
        check("bp_ok", 32'(frame_ok), 32'd1);
        for (int i = 0; i < 100; i++) begin
            if (i == 10) send_byte(HDR);
            else if (i == 50) send_byte(8'h3C);
            else tick();
        end
        check("bp_hold", 32'(out_data), 32'h11);
        check("bp_valid", 32'(out_valid), 32'd1);
        check("bp_ovr", 32'(ovr_cnt), 32'd2);
        got_q.delete(); got_last_q.delete();
        out_ready = 1'b1;
        wait_idle("bp_drain", 50, 1'b0);
        compare_payload("bp");

        // Randomized frames against the reference model
        last_code = 2'd3;
        for (int f = 0; f < 24; f++) begin
            pay_q.delete();
            if ($urandom_range(0, 7) == 0) len = 8'(MAX_LEN + 1 + int'($urandom_range(0, 40)));
            else len = 8'($urandom_range(0, MAX_LEN));
            if (int'(len) <= MAX_LEN) for (int i = 0; i < int'(len); i++) pay_q.push_back(8'($urandom));
            chk = model_chk(len);
            if ($urandom_range(0, 3) == 0) chk = chk ^ 8'($urandom_range(1, 255));
            code = model_code(len, chk);
            if ($urandom_range(0, 1) == 1) begin
                b = 8'($urandom);
                if (b == HDR) b = 8'h00;
                send_byte(b);
                check("rnd_noise_busy", 32'(busy), 32'd0);
            end
            got_q.delete(); got_last_q.delete();
            send_body(len, 3);
            if (code == 1) begin
                check("rnd_len_err", 32'(frame_err), 32'd1);
                last_code = 2'd1;
            end else begin
                send_byte(chk);
                check("rnd_ok", 32'(frame_ok), 32'(code == 0));
                check("rnd_err", 32'(frame_err), 32'(code != 0));
                if (code != 0) last_code = 2'(code);
                wait_idle("rnd_drain", 500, 1'b1);
                if (code == 0) compare_payload("rnd");
                else check("rnd_nodata", 32'(got_q.size()), 32'd0);
            end
            check("rnd_code", 32'(err_code), 32'(last_code));
        end

        // Reset in the middle of DATA, then noise in IDLE
        out_ready = 1'b1;
        send_byte(HDR); send_byte(8'd4); send_byte(8'h01);
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        idle(2);
        rst_n = 1'b1;
        idle(2);
        send_byte(8'h00);
        check("noise0_err", 32'(frame_err), 32'd0);
        check("noise0_busy", 32'(busy), 32'd0);
        send_byte(8'hFF);
        check("noise1_err", 32'(frame_err), 32'd0);
        check("noise1_busy", 32'(busy), 32'd0);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
